// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction over
// the req/ack bus, holds it for the decoder until the datapath retires it,
// then selects the next PC from NPCOp.
//
// state | meaning
// ------+----------------------------------------------------------------
// FETCH | request outstanding at pc; waiting for imem_ack
// READY | instr/pc held and valid; waiting for instr_done
// HALT  | misaligned next PC taken; bus idle until reset
module if_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    if_fetch_unit_if.master      imem,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4,
    input  logic                 instr_done,
    input  logic [1:0]           NPCOp,
    input  logic [15:0]          imm16,
    input  logic [25:0]          imm26,
    input  logic [31:0]          rs_data,
    output logic                 addr_err,
    output logic [CNT_W-1:0]     retired_cnt
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        READY = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] npc;
    logic [31:0] branch_off;
    logic        npc_misaligned;
    logic        fetch_take;
    logic        retire;

    assign pc_plus4   = pc_q + 32'd4;
    assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

    // Next-PC selection for the instruction currently being retired.
    always_comb begin
        npc = pc_plus4;
        case (NPCOp)
            NPC_PLUS4:  npc = pc_plus4;
            NPC_BRANCH: npc = pc_plus4 + branch_off;
            NPC_JUMP:   npc = {pc_plus4[31:28], imm26, 2'b00};
            NPC_JR:     npc = rs_data;
            default:    npc = pc_plus4;
        endcase
    end

    // Only a register-sourced target can leave the low bits non-zero.
    assign npc_misaligned = (npc[1:0] != 2'b00);

    // Next-state decode; acks outside FETCH and retirements outside READY are ignored.
    always_comb begin
        state_d    = state_q;
        fetch_take = 1'b0;
        retire     = 1'b0;
        case (state_q)
            FETCH: begin
                if (imem.imem_ack) begin
                    fetch_take = 1'b1;
                    state_d    = READY;
                end
            end
            READY: begin
                if (instr_done) begin
                    retire  = 1'b1;
                    state_d = npc_misaligned ? HALT : FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // PC advances only on retirement, so imem_addr stays stable during a fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= PC_RESET;
        end else if (retire) begin
            pc_q <= npc;
        end
    end

    // Capture the fetched word on the acknowledging edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= 32'h0000_0000;
        end else if (fetch_take) begin
            instr_q <= imem.imem_rdata;
        end
    end

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else if (retire && npc_misaligned) begin
            addr_err <= 1'b1;
        end
    end

    // Retired-instruction counter, including the one that causes a halt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= '0;
        end else if (retire) begin
            retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // The request is gated by rst so the bus is idle for the whole reset pulse.
    assign imem.imem_req  = (state_q == FETCH) && !rst;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = (state_q == READY);
    assign pc             = pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level model.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_done;
    logic [1:0]  NPCOp;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs_data;
    logic        addr_err;
    logic [31:0] retired_cnt;

    int n_chk;
    int n_err;
    bit chk_on;

    // Model of the architectural state as the spec describes it.
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_cnt;
    bit          exp_valid;
    bit          exp_halt;
    bit          exp_err;

    if_fetch_unit_if bus ();

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus.master),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr_done  (instr_done),
        .NPCOp       (NPCOp),
        .imm16       (imm16),
        .imm26       (imm26),
        .rs_data     (rs_data),
        .addr_err    (addr_err),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_npc(input logic [31:0] cur, input logic [1:0] op,
                                              input logic [15:0] i16, input logic [25:0] i26,
                                              input logic [31:0] rs);
        int signed off;
        logic [31:0] link;
        link = cur + 32'd4;
        off  = int'($signed(i16)) * 4;
        case (op)
            2'd0:    return link;
            2'd1:    return link + 32'(off);
            2'd2:    return (link & 32'hF000_0000) | (32'(i26) << 2);
            default: return rs;
        endcase
    endfunction

    task automatic model_reset();
        exp_pc    = 32'h0;
        exp_instr = 32'h0;
        exp_cnt   = 32'h0;
        exp_valid = 0;
        exp_halt  = 0;
        exp_err   = 0;
    endtask

    // One clock with the given inputs; the model then absorbs that edge.
    task automatic cyc(input logic ack, input logic [31:0] rd, input logic done,
                       input logic [1:0] op, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] rs);
        logic [31:0] n;
        bus.imem_ack   = ack;
        bus.imem_rdata = rd;
        instr_done     = done;
        NPCOp          = op;
        imm16          = i16;
        imm26          = i26;
        rs_data        = rs;
        @(posedge clk);
        #1;
        if (!exp_halt) begin
            if (!exp_valid) begin
                if (ack) begin
                    exp_instr = rd;
                    exp_valid = 1;
                end
            end else if (done) begin
                exp_cnt++;
                n = model_npc(exp_pc, op, i16, i26, rs);
                exp_pc    = n;
                exp_valid = 0;
                if (n[1:0] != 2'b00) begin
                    exp_halt = 1;
                    exp_err  = 1;
                end
            end
        end
    endtask

    task automatic fetch(input logic [31:0] rd);
        cyc(1'b1, rd, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0);
    endtask

    task automatic retire(input logic [1:0] op, input logic [15:0] i16,
                          input logic [25:0] i26, input logic [31:0] rs);
        cyc(1'b0, 32'h0, 1'b1, op, i16, i26, rs);
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_req"},   {31'b0, bus.imem_req}, 32'd0);
        chk({tag, "_valid"}, {31'b0, instr_valid},  32'd0);
        chk({tag, "_pc"},    pc,                    32'h0);
        chk({tag, "_instr"}, instr,                 32'h0);
        chk({tag, "_cnt"},   retired_cnt,           32'd0);
        chk({tag, "_err"},   {31'b0, addr_err},     32'd0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic mid_reset(input string tag);
        rst = 1'b1;
        #1;
        reset_values(tag);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk({tag, "_rel_req"},  {31'b0, bus.imem_req}, 32'd1);
        chk({tag, "_rel_addr"}, bus.imem_addr,         32'h0);
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_on && !rst) begin
            chk("imem_req", {31'b0, bus.imem_req}, {31'b0, (!exp_valid && !exp_halt)});
            if (!exp_valid && !exp_halt)
                chk("imem_addr", bus.imem_addr, exp_pc);
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
            if (exp_valid)
                chk("instr", instr, exp_instr);
            chk("pc", pc, exp_pc);
            chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
            chk("retired_cnt", retired_cnt, exp_cnt);
            chk("addr_err", {31'b0, addr_err}, {31'b0, exp_err});
        end
    end

    initial begin
        int halt_cycles;
        n_chk          = 0;
        n_err          = 0;
        chk_on         = 0;
        rst            = 1'b1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        instr_done     = 1'b0;
        NPCOp          = 2'd0;
        imm16          = 16'h0;
        imm26          = 26'h0;
        rs_data        = 32'h0;
        model_reset();
        #1;
        reset_values("por");
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_on = 1;

        // Sequential PLUS4 stream with zero-wait memory.
        for (int i = 0; i < 3; i++) begin
            fetch(32'h1000_0000 + 32'(i));
            chk("t1_instr", instr, 32'h1000_0000 + 32'(i));
            retire(2'd0, 16'h0, 26'h0, 32'h0);
            chk("t1_pc", pc, 32'(4 * (i + 1)));
        end
        chk("t1_cnt", retired_cnt, 32'd3);
        fetch(32'h1000_0003);
        retire(2'd0, 16'h0, 26'h0, 32'h0);

        // Delayed ack at 0x10.
        cyc(1'b0, 32'hDEAD_BEEF, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0);
        chk("t2_addr_hold", bus.imem_addr, 32'h10);
        cyc(1'b0, 32'hDEAD_BEEF, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0);
        chk("t2_req_hold", {31'b0, bus.imem_req}, 32'd1);
        fetch(32'hABCD_0123);
        chk("t2_valid", {31'b0, instr_valid}, 32'd1);
        chk("t2_instr", instr, 32'hABCD_0123);

        // Branches backward and forward from 0x40.
        retire(2'd3, 16'h0, 26'h0, 32'h40);
        fetch(32'h1);
        retire(2'd1, 16'hFFFE, 26'h0, 32'h0);
        chk("t3_br_back", pc, 32'h3C);
        fetch(32'h2);
        retire(2'd3, 16'h0, 26'h0, 32'h40);
        fetch(32'h3);
        retire(2'd1, 16'h0003, 26'h0, 32'h0);
        chk("t3_br_fwd", pc, 32'h50);

        // Jump keeps the upper nibble; JR takes rs_data.
        fetch(32'h4);
        retire(2'd3, 16'h0, 26'h0, 32'hF000_0000);
        fetch(32'h5);
        retire(2'd2, 16'h0, 26'h000_0100, 32'h0);
        chk("t4_jump", pc, 32'hF000_0400);
        fetch(32'h6);
        retire(2'd3, 16'h0, 26'h0, 32'h0000_1234);
        chk("t4_jr", pc, 32'h1234);

        // Misaligned JR halts; later acks and dones are ignored.
        fetch(32'h7);
        retire(2'd3, 16'h0, 26'h0, 32'h0000_1235);
        chk("t5_err", {31'b0, addr_err}, 32'd1);
        chk("t5_req", {31'b0, bus.imem_req}, 32'd0);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'h8, 1'b1, 2'd3, 16'h0, 26'h0, 32'h100);
        chk("t5_pc_frozen", pc, 32'h1235);
        mid_reset("t5_rst");

        // Reset with an ack pending, then reset while holding an instruction.
        fetch(32'h9);
        retire(2'd0, 16'h0, 26'h0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 2'd0, 16'h0, 26'h0, 32'h0);
        mid_reset("t6_fetch");
        fetch(32'hA);
        mid_reset("t6_ready");
        fetch(32'hB);
        retire(2'd0, 16'h0, 26'h0, 32'h0);
        chk("t6_cnt", retired_cnt, 32'd1);

        // Random traffic, including stray acks/dones and occasional resets.
        halt_cycles = 0;
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rs;
            rs = $urandom();
            if ($urandom_range(0, 29) != 0)
                rs[1:0] = 2'b00;
            cyc(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 16'($urandom()), 26'($urandom()), rs);
            if (exp_halt)
                halt_cycles++;
            if (halt_cycles > 3 || $urandom_range(0, 199) == 0) begin
                halt_cycles = 0;
                mid_reset("rnd_rst");
            end
        end

        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
